s_trap_ctrl: RTL and testbench

Supervisor trap sequencer that sits between the pipeline and `supervisor_csr`. It arbitrates simultaneous exception reports, gated supervisor interrupts and SRET requests, and drains the pipeline before committing the winning event. It then drives the CSR block's `exception` / `return_from_exception` strobes and issues a single PC/mode redirect to fetch.

---
 rtl/s_trap_pkg.sv | 35 +++
 rtl/s_trap_prio_enc.sv | 57 +++++
 rtl/s_trap_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_s_trap_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/s_trap_pkg.sv
// Shared types and constants for the supervisor trap sequencer.
package s_trap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_e;

   localparam logic [3:0] CAUSE_SSI     = 4'd1;
   localparam logic [3:0] CAUSE_STI     = 4'd5;
   localparam logic [3:0] CAUSE_SEI     = 4'd9;
   localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;

   localparam logic [1:0] STVEC_DIRECT   = 2'd0;
   localparam logic [1:0] STVEC_VECTORED = 2'd1;

   localparam logic [1:0] MODE_U = 2'b00;
   localparam logic [1:0] MODE_S = 2'b01;
   localparam logic [1:0] MODE_M = 2'b11;

   // S-level interrupts are taken from U always, from S only with SIE set, never from M.
   function automatic logic irq_eligible(input logic [1:0] mode, input logic sie);
      logic ok;
      case (mode)
         MODE_U:  ok = 1'b1;
         MODE_S:  ok = sie;
         MODE_M:  ok = 1'b0;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/s_trap_prio_enc.sv
// Fixed-priority pick of the oldest exception source and the highest interrupt.
module s_trap_prio_enc
   import s_trap_pkg::*;
#(
   parameter int NUM_EXC_SRC = 4
) (
   input  logic [NUM_EXC_SRC-1:0] exc_valid,
   input  logic                   irq_sei,
   input  logic                   irq_ssi,
   input  logic                   irq_sti,
   input  logic                   irq_en,
   output logic [NUM_EXC_SRC-1:0] exc_gnt,
   output logic                   exc_hit,
   output logic                   irq_hit,
   output logic [3:0]             irq_cause
);

   logic found_s;

   // One-hot grant to the lowest-index reporting source.
   always_comb begin
      exc_gnt = {NUM_EXC_SRC{1'b0}};
      found_s = 1'b0;
      for (int i = 0; i < NUM_EXC_SRC; i++) begin
         if (exc_valid[i] && !found_s) begin
            exc_gnt[i] = 1'b1;
            found_s    = 1'b1;
         end else begin
            exc_gnt[i] = 1'b0;
         end
      end
      exc_hit = found_s;
   end

   // Interrupt order SEI > SSI > STI, masked by eligibility.
   always_comb begin
      irq_hit   = 1'b0;
      irq_cause = 4'd0;
      if (!irq_en) begin
         irq_hit   = 1'b0;
         irq_cause = 4'd0;
      end else if (irq_sei) begin
         irq_hit   = 1'b1;
         irq_cause = CAUSE_SEI;
      end else if (irq_ssi) begin
         irq_hit   = 1'b1;
         irq_cause = CAUSE_SSI;
      end else if (irq_sti) begin
         irq_hit   = 1'b1;
         irq_cause = CAUSE_STI;
      end else begin
         irq_hit   = 1'b0;
         irq_cause = 4'd0;
      end
   end

endmodule

// File: rtl/s_trap_ctrl.sv
// Supervisor trap sequencer: capture winning event, drain pipeline, strobe CSR block, redirect fetch.
module s_trap_ctrl
   import s_trap_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int NUM_EXC_SRC = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_EXC_SRC-1:0]            exc_valid,
   input  logic [NUM_EXC_SRC*4-1:0]          exc_code,
   input  logic [NUM_EXC_SRC*DATA_WIDTH-1:0] exc_value,
   input  logic [NUM_EXC_SRC*DATA_WIDTH-1:0] exc_pc,
   input  logic                              irq_sei,
   input  logic                              irq_ssi,
   input  logic                              irq_sti,
   input  logic                              sstatus_sie,
   input  logic [1:0]                        current_mode,
   input  logic [DATA_WIDTH-1:0]             int_pc,
   input  logic                              sret_req,
   input  logic [DATA_WIDTH-1:0]             sret_pc,
   input  logic [DATA_WIDTH-1:0]             stvec,
   input  logic [DATA_WIDTH-1:0]             return_pc,
   input  logic [1:0]                        return_mode,
   output logic                              pipe_drain_req,
   input  logic                              pipe_idle,
   output logic                              exception,
   output logic [3:0]                        exception_code,
   output logic                              exc_is_irq,
   output logic [DATA_WIDTH-1:0]             exception_value,
   output logic [DATA_WIDTH-1:0]             exception_pc,
   output logic                              return_from_exception,
   output logic                              redirect_valid,
   output logic [DATA_WIDTH-1:0]             redirect_pc,
   output logic [1:0]                        new_mode,
   output logic                              busy
);

   localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

   trap_state_e             state_r;
   logic                    is_sret_r;
   logic [3:0]              code_r;
   logic                    irq_r;
   logic [DATA_WIDTH-1:0]   value_r;
   logic [DATA_WIDTH-1:0]   pc_r;

   logic [NUM_EXC_SRC-1:0]  exc_gnt_s;
   logic                    exc_hit_s;
   logic                    irq_hit_s;
   logic [3:0]              irq_cause_s;
   logic [3:0]              sel_code_s;
   logic [DATA_WIDTH-1:0]   sel_value_s;
   logic [DATA_WIDTH-1:0]   sel_pc_s;
   logic                    evt_s;
   logic                    nxt_sret_s;
   logic                    nxt_irq_s;
   logic [3:0]              nxt_code_s;
   logic [DATA_WIDTH-1:0]   nxt_value_s;
   logic [DATA_WIDTH-1:0]   nxt_pc_s;

   // Vectored mode offsets only interrupts; reserved modes fall back to the base.
   function automatic logic [DATA_WIDTH-1:0] trap_target(input logic [DATA_WIDTH-1:0] tvec,
                                                         input logic [3:0] cause,
                                                         input logic is_irq);
      logic [DATA_WIDTH-1:0] base;
      logic [DATA_WIDTH-1:0] offs;
      logic [DATA_WIDTH-1:0] tgt;
      base = {tvec[DATA_WIDTH-1:2], 2'b00};
      offs = {{(DATA_WIDTH-6){1'b0}}, cause, 2'b00};
      case (tvec[1:0])
         STVEC_VECTORED: tgt = is_irq ? (base + offs) : base;
         STVEC_DIRECT:   tgt = base;
         default:        tgt = base;
      endcase
      return tgt;
   endfunction

   s_trap_prio_enc #(.NUM_EXC_SRC(NUM_EXC_SRC)) u_prio (
      .exc_valid (exc_valid),
      .irq_sei   (irq_sei),
      .irq_ssi   (irq_ssi),
      .irq_sti   (irq_sti),
      .irq_en    (irq_eligible(current_mode, sstatus_sie)),
      .exc_gnt   (exc_gnt_s),
      .exc_hit   (exc_hit_s),
      .irq_hit   (irq_hit_s),
      .irq_cause (irq_cause_s)
   );

   // AND-OR mux of the granted source's fields.
   always_comb begin
      sel_code_s  = 4'd0;
      sel_value_s = ZERO_W;
      sel_pc_s    = ZERO_W;
      for (int i = 0; i < NUM_EXC_SRC; i++) begin
         sel_code_s  = sel_code_s  | (exc_code[4*i +: 4] & {4{exc_gnt_s[i]}});
         sel_value_s = sel_value_s | (exc_value[DATA_WIDTH*i +: DATA_WIDTH] & {DATA_WIDTH{exc_gnt_s[i]}});
         sel_pc_s    = sel_pc_s    | (exc_pc[DATA_WIDTH*i +: DATA_WIDTH] & {DATA_WIDTH{exc_gnt_s[i]}});
      end
   end

   // Resolve the candidate event; SRET from U becomes an illegal-instruction trap.
   always_comb begin
      evt_s       = 1'b0;
      nxt_sret_s  = 1'b0;
      nxt_irq_s   = 1'b0;
      nxt_code_s  = 4'd0;
      nxt_value_s = ZERO_W;
      nxt_pc_s    = ZERO_W;
      if (exc_hit_s) begin
         evt_s       = 1'b1;
         nxt_code_s  = sel_code_s;
         nxt_value_s = sel_value_s;
         nxt_pc_s    = sel_pc_s;
      end else if (irq_hit_s) begin
         evt_s      = 1'b1;
         nxt_irq_s  = 1'b1;
         nxt_code_s = irq_cause_s;
         nxt_pc_s   = int_pc;
      end else if (sret_req) begin
         evt_s    = 1'b1;
         nxt_pc_s = sret_pc;
         if (current_mode == MODE_U) begin
            nxt_code_s = CAUSE_ILLEGAL;
         end else begin
            nxt_sret_s = 1'b1;
         end
      end else begin
         evt_s = 1'b0;
      end
   end

   // Sequencer FSM; strobes and payload outputs default to zero every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r               <= ST_IDLE;
         is_sret_r             <= 1'b0;
         code_r                <= 4'd0;
         irq_r                 <= 1'b0;
         value_r               <= ZERO_W;
         pc_r                  <= ZERO_W;
         pipe_drain_req        <= 1'b0;
         exception             <= 1'b0;
         exception_code        <= 4'd0;
         exc_is_irq            <= 1'b0;
         exception_value       <= ZERO_W;
         exception_pc          <= ZERO_W;
         return_from_exception <= 1'b0;
         redirect_valid        <= 1'b0;
         redirect_pc           <= ZERO_W;
         new_mode              <= MODE_U;
         busy                  <= 1'b0;
      end else begin
         exception             <= 1'b0;
         exception_code        <= 4'd0;
         exc_is_irq            <= 1'b0;
         exception_value       <= ZERO_W;
         exception_pc          <= ZERO_W;
         return_from_exception <= 1'b0;
         redirect_valid        <= 1'b0;
         redirect_pc           <= ZERO_W;
         new_mode              <= MODE_U;
         case (state_r)
            ST_IDLE: begin
               if (evt_s) begin
                  state_r        <= ST_DRAIN;
                  is_sret_r      <= nxt_sret_s;
                  code_r         <= nxt_code_s;
                  irq_r          <= nxt_irq_s;
                  value_r        <= nxt_value_s;
                  pc_r           <= nxt_pc_s;
                  pipe_drain_req <= 1'b1;
                  busy           <= 1'b1;
               end else begin
                  pipe_drain_req <= 1'b0;
                  busy           <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (pipe_idle) begin
                  state_r        <= ST_COMMIT;
                  pipe_drain_req <= 1'b0;
                  if (is_sret_r) begin
                     return_from_exception <= 1'b1;
                  end else begin
                     exception       <= 1'b1;
                     exception_code  <= code_r;
                     exc_is_irq      <= irq_r;
                     exception_value <= value_r;
                     exception_pc    <= pc_r;
                  end
               end else begin
                  pipe_drain_req <= 1'b1;
               end
            end
            ST_COMMIT: begin
               state_r        <= ST_REDIRECT;
               redirect_valid <= 1'b1;
               if (is_sret_r) begin
                  redirect_pc <= return_pc;
                  new_mode    <= return_mode;
               end else begin
                  redirect_pc <= trap_target(stvec, code_r, irq_r);
                  new_mode    <= MODE_S;
               end
            end
            ST_REDIRECT: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
            end
            default: begin
               state_r        <= ST_IDLE;
               pipe_drain_req <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s_trap_ctrl.sv
// Scoreboard bench for s_trap_ctrl: stimulus pushes expected events, a negedge monitor checks them.
module tb_s_trap_ctrl;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    exc_valid;
   logic [15:0]   exc_code;
   logic [255:0]  exc_value;
   logic [255:0]  exc_pc;
   logic          irq_sei, irq_ssi, irq_sti, sstatus_sie;
   logic [1:0]    current_mode;
   logic [63:0]   int_pc, sret_pc, stvec, return_pc;
   logic          sret_req;
   logic [1:0]    return_mode;
   logic          pipe_drain_req, pipe_idle;
   logic          exception, exc_is_irq, return_from_exception, redirect_valid, busy;
   logic [3:0]    exception_code;
   logic [63:0]   exception_value, exception_pc, redirect_pc;
   logic [1:0]    new_mode;

   typedef struct {
      logic        is_sret;
      logic [3:0]  code;
      logic        irq;
      logic [63:0] value;
      logic [63:0] pc;
      logic [63:0] rpc;
      logic [1:0]  rmode;
      int          commit_cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   s_trap_ctrl dut (
      .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_value(exc_value),
      .exc_pc(exc_pc), .irq_sei(irq_sei), .irq_ssi(irq_ssi), .irq_sti(irq_sti),
      .sstatus_sie(sstatus_sie), .current_mode(current_mode), .int_pc(int_pc),
      .sret_req(sret_req), .sret_pc(sret_pc), .stvec(stvec), .return_pc(return_pc),
      .return_mode(return_mode), .pipe_drain_req(pipe_drain_req), .pipe_idle(pipe_idle),
      .exception(exception), .exception_code(exception_code), .exc_is_irq(exc_is_irq),
      .exception_value(exception_value), .exception_pc(exception_pc),
      .return_from_exception(return_from_exception), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .new_mode(new_mode), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_events();
      exc_valid = 4'd0;
      exc_code  = 16'd0;
      exc_value = 256'd0;
      exc_pc    = 256'd0;
      irq_sei   = 1'b0;
      irq_ssi   = 1'b0;
      irq_sti   = 1'b0;
      sret_req  = 1'b0;
   endtask

   task automatic wait_done();
      bit done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      check("sequence_done", {63'd0, done}, 64'd1);
   endtask

   // Inputs are already set at a negedge; capture happens at the next posedge.
   task automatic issue(input exp_t e, input int stall, input bit inject);
      @(posedge clk);
      #1;
      e.commit_cyc = cyc + 1 + stall;
      sb_q.push_back(e);
      @(negedge clk);
      clear_events();
      if (stall > 0) begin
         pipe_idle = 1'b0;
         for (int k = 0; k < stall; k++) begin
            check("drain_req_held", {63'd0, pipe_drain_req}, 64'd1);
            check("no_early_commit", {63'd0, exception}, 64'd0);
            if (inject) exc_valid = 4'b0001;
            @(negedge clk);
         end
         exc_valid = 4'd0;
         pipe_idle = 1'b1;
      end
      wait_done();
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (exception || return_from_exception || redirect_valid)
            check("strobe_onehot", {63'd0, ($countones({exception, return_from_exception, redirect_valid}) > 1)}, 64'd0);
         if (exception || return_from_exception) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_commit: got exc=%0b sret=%0b expected none", exception, return_from_exception);
            end else begin
               mon_e = sb_q[0];
               check("commit_kind", {63'd0, return_from_exception}, {63'd0, mon_e.is_sret});
               check("commit_cycle", cyc, mon_e.commit_cyc);
               if (!mon_e.is_sret) begin
                  check("exc_code", {60'd0, exception_code}, {60'd0, mon_e.code});
                  check("exc_is_irq", {63'd0, exc_is_irq}, {63'd0, mon_e.irq});
                  check("exc_value", exception_value, mon_e.value);
                  check("exc_pc", exception_pc, mon_e.pc);
               end
            end
         end
         if (redirect_valid) begin
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_redirect: got pc=%0h expected none", redirect_pc);
            end else begin
               mon_e = sb_q.pop_front();
               check("redirect_cycle", cyc, mon_e.commit_cyc + 1);
               check("redirect_pc", redirect_pc, mon_e.rpc);
               check("new_mode", {62'd0, new_mode}, {62'd0, mon_e.rmode});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_events();
      sstatus_sie = 1'b0; current_mode = 2'b01; int_pc = 64'd0; sret_pc = 64'd0;
      stvec = 64'd0; return_pc = 64'd0; return_mode = 2'b00; pipe_idle = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_exception", {63'd0, exception}, 64'd0);
      check("rst_redirect_pc", redirect_pc, 64'd0);
      check("rst_new_mode", {62'd0, new_mode}, 64'd0);
      check("rst_drain_req", {63'd0, pipe_drain_req}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: oldest reporter wins, direct vector
      stvec = 64'h8000_0000; current_mode = 2'b01; sstatus_sie = 1'b1;
      exc_valid = 4'b0110;
      exc_code[7:4] = 4'd5;  exc_pc[127:64] = 64'h1000;  exc_value[127:64] = 64'hDEAD;
      exc_code[11:8] = 4'd7; exc_pc[191:128] = 64'h2000; exc_value[191:128] = 64'hBEEF;
      issue('{1'b0, 4'd5, 1'b0, 64'hDEAD, 64'h1000, 64'h8000_0000, 2'b01, 0}, 0, 1'b0);

      // 2: SEI beats STI, vectored target base + 9*4
      stvec = 64'h8000_0001; current_mode = 2'b00; sstatus_sie = 1'b0; int_pc = 64'h4444;
      irq_sti = 1'b1; irq_sei = 1'b1;
      issue('{1'b0, 4'd9, 1'b1, 64'd0, 64'h4444, 64'h8000_0024, 2'b01, 0}, 0, 1'b0);

      // 3: gating in S with SIE=0 and in M, then enable
      current_mode = 2'b01; sstatus_sie = 1'b0; irq_ssi = 1'b1; int_pc = 64'h5550;
      repeat (3) begin @(negedge clk); check("gated_s_busy", {63'd0, busy}, 64'd0); end
      current_mode = 2'b11; sstatus_sie = 1'b1;
      repeat (3) begin @(negedge clk); check("gated_m_busy", {63'd0, busy}, 64'd0); end
      current_mode = 2'b01;
      issue('{1'b0, 4'd1, 1'b1, 64'd0, 64'h5550, 64'h8000_0004, 2'b01, 0}, 0, 1'b0);

      // 4a: SRET from S returns to sepc / SPP
      sret_req = 1'b1; sret_pc = 64'h3000; return_pc = 64'h2000; return_mode = 2'b00;
      issue('{1'b1, 4'd0, 1'b0, 64'd0, 64'd0, 64'h2000, 2'b00, 0}, 0, 1'b0);

      // 4b: SRET from U is illegal; vectored stvec but not an interrupt -> base
      current_mode = 2'b00; sret_req = 1'b1;
      issue('{1'b0, 4'd2, 1'b0, 64'd0, 64'h3000, 64'h8000_0000, 2'b01, 0}, 0, 1'b0);

      // 5: 5-cycle drain stall with a late reporter that must be dropped
      stvec = 64'h8000_0000; current_mode = 2'b11;
      exc_valid = 4'b1000; exc_code[15:12] = 4'hB; exc_pc[255:192] = 64'h7000; exc_value[255:192] = 64'h77;
      issue('{1'b0, 4'hB, 1'b0, 64'h77, 64'h7000, 64'h8000_0000, 2'b01, 0}, 5, 1'b1);

      // 7: vectored target wraps modulo 2^64
      stvec = 64'hFFFF_FFFF_FFFF_FFF1; current_mode = 2'b00; int_pc = 64'h6000; irq_sei = 1'b1;
      issue('{1'b0, 4'd9, 1'b1, 64'd0, 64'h6000, 64'h14, 2'b01, 0}, 0, 1'b0);

      // 8: reserved stvec mode 11 uses base only
      stvec = 64'h9000_0003; irq_sti = 1'b1;
      issue('{1'b0, 4'd5, 1'b1, 64'd0, 64'h6000, 64'h9000_0000, 2'b01, 0}, 0, 1'b0);

      // 6: reset while draining abandons the event
      exc_valid = 4'b0001; exc_code[3:0] = 4'd3; pipe_idle = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clear_events();
      check("mid_busy", {63'd0, busy}, 64'd1);
      check("mid_drain_req", {63'd0, pipe_drain_req}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_drain_req", {63'd0, pipe_drain_req}, 64'd0);
      check("arst_exception", {63'd0, exception}, 64'd0);
      check("arst_redirect_valid", {63'd0, redirect_valid}, 64'd0);
      check("arst_redirect_pc", redirect_pc, 64'd0);
      check("arst_exc_code", {60'd0, exception_code}, 64'd0);
      @(negedge clk);
      rst = 1'b0; pipe_idle = 1'b1;
      repeat (10) @(negedge clk);
      check("post_rst_busy", {63'd0, busy}, 64'd0);
      check("post_rst_queue", sb_q.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
